// File: rtl/filtro_teclado_fifo_if.sv
// Bus between the PS/2 receiver, the scan-code filter and the consumer.
// master = receiver/consumer side, slave = filtro_teclado_fifo.
interface filtro_teclado_fifo_if;
   logic [7:0] key_code;
   logic       got_code_tick;
   logic       bit_paridad;
   logic       leer;
   logic [7:0] dato_listo;
   logic       dato_valido;
   logic       tick;
   logic       error_paridad;
   logic       fifo_lleno;
   logic       desborde;
   logic [7:0] cont_errores;

   modport master (
      output key_code, got_code_tick, bit_paridad, leer,
      input  dato_listo, dato_valido, tick, error_paridad, fifo_lleno, desborde, cont_errores
   );

   modport slave (
      input  key_code, got_code_tick, bit_paridad, leer,
      output dato_listo, dato_valido, tick, error_paridad, fifo_lleno, desborde, cont_errores
   );
endinterface

// File: rtl/filtro_teclado_fifo.sv
// PS/2 scan-code filter: parity check, F0 break-sequence removal, key-table match,
// small FIFO of accepted codes and a hold-window output stage.
// Optional feature: define FILTRO_CONTEO_ERR_EN to build the saturating parity-error
// counter on cont_errores; otherwise cont_errores is tied to 8'h00.
module filtro_teclado_fifo #(
   parameter int                    NUM_KEYS    = 9,
   parameter logic [8*NUM_KEYS-1:0] KEY_TABLE   = 72'h05_06_04_0C_03_1D_1C_1B_23,
   parameter int                    FIFO_DEPTH  = 4,
   parameter int                    HOLD_CYCLES = 4
) (
   input logic                  reloj,
   input logic                  reset,
   filtro_teclado_fifo_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [AW:0]   PTR_UNO = (AW + 1)'(1);
   localparam logic [CW-1:0] CNT_UNO = CW'(1);
   localparam logic [CW-1:0] CNT_FIN = CW'(HOLD_CYCLES - 1);

   typedef enum logic {
      ST_NORMAL,
      ST_BREAK
   } estado_t;

   // Registered receiver frame
   logic [7:0] code_q;
   logic       strobe_q;
   logic       paridad_ok_q;

   logic       trama_valida;
   logic       error_paridad;
   logic       en_tabla;

   estado_t    estado, estado_sig;
   logic       push_req;

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        vacia, llena, push, pop;

   logic [7:0]    dato_q;
   logic          valido_q;
   logic          tick_q;
   logic [CW-1:0] cnt_q;
   logic          desborde_q;

   // Capture the receiver strobe, code and parity verdict
   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge reloj or negedge reset) begin
      if (!reset) begin
         code_q       <= 8'h00;
         strobe_q     <= 1'b0;
         paridad_ok_q <= 1'b0;
      end else begin
         code_q       <= bus.key_code;
         strobe_q     <= bus.got_code_tick;
         paridad_ok_q <= ^{bus.key_code, bus.bit_paridad};
      end
   end

   assign trama_valida  = strobe_q & paridad_ok_q;
   assign error_paridad = strobe_q & ~paridad_ok_q;

   // Match the registered code against the key table
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      en_tabla = 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (code_q == KEY_TABLE[8*i +: 8]) en_tabla = 1'b1;
      end
   end

   // Break FSM state register
   always_ff @(posedge reloj or negedge reset) begin
      if (!reset) estado <= ST_NORMAL;
      else        estado <= estado_sig;
   end

   // Break FSM next state: only valid-parity frames move it
   always_comb begin
      estado_sig = estado;
      if (trama_valida) begin
         case (estado)
            ST_NORMAL: if (code_q == 8'hF0) estado_sig = ST_BREAK;
            ST_BREAK:  estado_sig = ST_NORMAL;
            default:   estado_sig = ST_NORMAL;
         endcase
      end
   end

   // Break FSM output: request a push for accepted make codes
   always_comb begin
      push_req = 1'b0;
      if (trama_valida && estado == ST_NORMAL && code_q != 8'hF0 && code_q != 8'hE0)
         push_req = en_tabla;
   end

   assign vacia = (wr_ptr == rd_ptr);
   assign llena = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = ~valido_q & ~vacia;
   assign push  = push_req & (~llena | pop);

   // FIFO storage write port
   // NOTE: storage is not reset; pointers alone define which entries are valid.
   always_ff @(posedge reloj) begin
      if (push) mem[wr_ptr[AW-1:0]] <= code_q;
   end

   // FIFO pointers and sticky overflow flag
   always_ff @(posedge reloj or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         desborde_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_UNO;
         if (pop)  rd_ptr <= rd_ptr + PTR_UNO;
         if (push_req && llena && !pop) desborde_q <= 1'b1;
      end
   end

   // Output stage: load a code into a hold window, end it on expiry or leer
   always_ff @(posedge reloj or negedge reset) begin
      if (!reset) begin
         dato_q   <= 8'h00;
         valido_q <= 1'b0;
         tick_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         tick_q <= pop;
         if (pop) begin
            dato_q   <= mem[rd_ptr[AW-1:0]];
            valido_q <= 1'b1;
            cnt_q    <= '0;
         end else if (valido_q) begin
            if (bus.leer || cnt_q == CNT_FIN) begin
               dato_q   <= 8'h00;
               valido_q <= 1'b0;
               cnt_q    <= '0;
            end else begin
               cnt_q <= cnt_q + CNT_UNO;
            end
         end
      end
   end

`ifdef FILTRO_CONTEO_ERR_EN
   logic [7:0] cont_q;

   // Saturating count of parity-error pulses
   always_ff @(posedge reloj or negedge reset) begin
      if (!reset)                              cont_q <= 8'h00;
      else if (error_paridad && cont_q != 8'hFF) cont_q <= cont_q + 8'd1;
   end

   assign bus.cont_errores = cont_q;
`else
   assign bus.cont_errores = 8'h00;
`endif

   assign bus.dato_listo    = dato_q;
   assign bus.dato_valido   = valido_q;
   assign bus.tick          = tick_q;
   assign bus.error_paridad = error_paridad;
   assign bus.fifo_lleno    = llena;
   assign bus.desborde      = desborde_q;

endmodule

// File: tb/tb_filtro_teclado_fifo.sv
// Self-checking bench for filtro_teclado_fifo: single-frame vector table plus
// hand-written sequences for overflow, early acknowledge and mid-window reset.
module tb_filtro_teclado_fifo;

   logic reloj = 1'b0;
   logic reset = 1'b1;

   filtro_teclado_fifo_if bus ();

   filtro_teclado_fifo dut (
      .reloj (reloj),
      .reset (reset),
      .bus   (bus)
   );

   always #5 reloj = ~reloj;

   typedef struct {
      logic [7:0] code;
      logic       par_bien;
      logic       acepta;
      string      nombre;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [7:0] recibidos [$];
   int         ciclos_validos;

   task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
      checks++;
      if (actual !== esperado) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nombre, actual, esperado);
      end
   endtask

   function automatic logic par_impar(input logic [7:0] c);
      return ~^c;
   endfunction

   function automatic vec_t mk(input logic [7:0] c, input logic pb, input logic acc, input string n);
      vec_t v;
      v.code = c; v.par_bien = pb; v.acepta = acc; v.nombre = n;
      return v;
   endfunction

   task automatic pulso_reset();
      @(negedge reloj);
      reset = 1'b0;
      @(negedge reloj);
      @(negedge reloj);
      reset = 1'b1;
   endtask

   // Drive a strobe for this cycle (caller is at a negedge)
   task automatic drive(input logic [7:0] c, input logic pb);
      bus.key_code      = c;
      bus.bit_paridad   = pb ? par_impar(c) : ~par_impar(c);
      bus.got_code_tick = 1'b1;
   endtask

   task automatic muestrear();
      if (bus.tick === 1'b1) recibidos.push_back(bus.dato_listo);
      if (bus.dato_valido === 1'b1) ciclos_validos++;
   endtask

   // One frame from idle: strobe in cycle 0, watch cycles 1..8
   task automatic aplicar(input vec_t v);
      logic en_ventana;
      @(negedge reloj);
      drive(v.code, v.par_bien);
      @(negedge reloj);
      bus.got_code_tick = 1'b0;
      check({v.nombre, " error_paridad c1"}, bus.error_paridad, !v.par_bien);
      check({v.nombre, " dato_valido c1"}, bus.dato_valido, 1'b0);
      for (int c = 2; c <= 8; c++) begin
         @(negedge reloj);
         en_ventana = v.acepta && c >= 3 && c <= 6;
         check($sformatf("%s dato_valido c%0d", v.nombre, c), bus.dato_valido, en_ventana);
         check($sformatf("%s dato_listo c%0d", v.nombre, c), bus.dato_listo, en_ventana ? v.code : 8'h00);
         check($sformatf("%s tick c%0d", v.nombre, c), bus.tick, v.acepta && c == 3);
         check($sformatf("%s error_paridad c%0d", v.nombre, c), bus.error_paridad, 1'b0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tabla [14];
      logic [7:0] codes4 [6];
      logic [7:0] exp_cont;

      tabla[0]  = mk(8'h1C, 1'b1, 1'b1, "valid_1C");
      tabla[1]  = mk(8'h23, 1'b1, 1'b1, "valid_23_entry0");
      tabla[2]  = mk(8'h05, 1'b1, 1'b1, "valid_05_entry8");
      tabla[3]  = mk(8'h1C, 1'b0, 1'b0, "badpar_1C");
      tabla[4]  = mk(8'h00, 1'b1, 1'b0, "notable_00");
      tabla[5]  = mk(8'hE0, 1'b1, 1'b0, "ext_E0");
      tabla[6]  = mk(8'hF0, 1'b1, 1'b0, "break_F0");
      tabla[7]  = mk(8'h1C, 1'b1, 1'b0, "release_1C");
      tabla[8]  = mk(8'h1C, 1'b1, 1'b1, "after_release_1C");
      tabla[9]  = mk(8'hF0, 1'b1, 1'b0, "break2_F0");
      tabla[10] = mk(8'h1B, 1'b0, 1'b0, "badpar_in_break_1B");
      tabla[11] = mk(8'h1B, 1'b1, 1'b0, "release_1B");
      tabla[12] = mk(8'h1B, 1'b1, 1'b1, "after_release_1B");
      tabla[13] = mk(8'h5A, 1'b1, 1'b0, "notable_5A");
`ifdef FILTRO_CONTEO_ERR_EN
      exp_cont = 8'd2;
`else
      exp_cont = 8'd0;
`endif

      bus.key_code      = 8'h00;
      bus.got_code_tick = 1'b0;
      bus.bit_paridad   = 1'b0;
      bus.leer          = 1'b0;

      // Reset state
      #2 reset = 1'b0;
      #1;
      check("reset dato_valido", bus.dato_valido, 1'b0);
      check("reset dato_listo", bus.dato_listo, 8'h00);
      check("reset tick", bus.tick, 1'b0);
      check("reset error_paridad", bus.error_paridad, 1'b0);
      check("reset fifo_lleno", bus.fifo_lleno, 1'b0);
      check("reset desborde", bus.desborde, 1'b0);
      check("reset cont_errores", bus.cont_errores, 8'h00);
      @(negedge reloj);
      @(negedge reloj);
      reset = 1'b1;

      // Single-frame vectors (FSM state carries from one vector to the next)
      for (int i = 0; i < 14; i++) aplicar(tabla[i]);
      check("cont_errores after table", bus.cont_errores, exp_cont);
      check("desborde after table", bus.desborde, 1'b0);

      // Six codes back-to-back, never acknowledged
      pulso_reset();
      codes4 = '{8'h23, 8'h1B, 8'h1C, 8'h1D, 8'h03, 8'h0C};
      recibidos.delete();
      ciclos_validos = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge reloj);
         drive(codes4[i], 1'b1);
         muestrear();
      end
      @(negedge reloj);
      bus.got_code_tick = 1'b0;
      muestrear();
      check("burst fifo_lleno c6", bus.fifo_lleno, 1'b1);
      check("burst desborde c6", bus.desborde, 1'b0);
      @(negedge reloj);
      muestrear();
      check("burst desborde c7", bus.desborde, 1'b1);
      for (int c = 8; c <= 34; c++) begin
         @(negedge reloj);
         muestrear();
      end
      check("burst delivered count", recibidos.size(), 5);
      for (int i = 0; i < 5 && i < recibidos.size(); i++)
         check($sformatf("burst code %0d", i), recibidos[i], codes4[i]);
      check("burst valid cycles", ciclos_validos, 20);
      check("burst desborde sticky", bus.desborde, 1'b1);
      check("burst fifo_lleno drained", bus.fifo_lleno, 1'b0);

      // Early acknowledge; leer while idle is ignored
      pulso_reset();
      @(negedge reloj);                      // c0
      drive(8'h1C, 1'b1);
      @(negedge reloj);                      // c1
      drive(8'h23, 1'b1);
      bus.leer = 1'b1;
      @(negedge reloj);                      // c2
      bus.got_code_tick = 1'b0;
      @(negedge reloj);                      // c3
      bus.leer = 1'b0;
      check("leer first window dato_valido", bus.dato_valido, 1'b1);
      check("leer first window dato_listo", bus.dato_listo, 8'h1C);
      check("leer first window tick", bus.tick, 1'b1);
      @(negedge reloj);                      // c4: second hold cycle
      check("leer c4 dato_valido", bus.dato_valido, 1'b1);
      check("leer c4 tick", bus.tick, 1'b0);
      bus.leer = 1'b1;
      @(negedge reloj);                      // c5: gap
      bus.leer = 1'b0;
      check("leer gap dato_valido", bus.dato_valido, 1'b0);
      check("leer gap dato_listo", bus.dato_listo, 8'h00);
      @(negedge reloj);                      // c6
      check("leer second window dato_valido", bus.dato_valido, 1'b1);
      check("leer second window dato_listo", bus.dato_listo, 8'h23);
      check("leer second window tick", bus.tick, 1'b1);
      @(negedge reloj);
      @(negedge reloj);
      @(negedge reloj);                      // c9
      check("leer second window last cycle", bus.dato_valido, 1'b1);
      @(negedge reloj);                      // c10
      check("leer second window ended", bus.dato_valido, 1'b0);

      // Overflow again, then reset mid-window with the FIFO three deep
      for (int i = 0; i < 6; i++) begin
         @(negedge reloj);
         drive(codes4[i], 1'b1);
      end
      @(negedge reloj);
      bus.got_code_tick = 1'b0;
      for (int c = 0; c < 30; c++) @(negedge reloj);
      check("pre-reset desborde", bus.desborde, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge reloj);                   // c0..c3
         drive(codes4[i], 1'b1);
      end
      @(negedge reloj);                      // c4
      bus.got_code_tick = 1'b0;
      @(negedge reloj);                      // c5
      check("pre-reset dato_valido", bus.dato_valido, 1'b1);
      reset = 1'b0;
      #1;
      check("async reset dato_valido", bus.dato_valido, 1'b0);
      check("async reset dato_listo", bus.dato_listo, 8'h00);
      check("async reset tick", bus.tick, 1'b0);
      check("async reset fifo_lleno", bus.fifo_lleno, 1'b0);
      check("async reset desborde", bus.desborde, 1'b0);
      check("async reset cont_errores", bus.cont_errores, 8'h00);
      @(negedge reloj);
      @(negedge reloj);
      reset = 1'b1;
      ciclos_validos = 0;
      recibidos.delete();
      for (int c = 0; c < 30; c++) begin
         @(negedge reloj);
         muestrear();
      end
      check("post-reset stale valid cycles", ciclos_validos, 0);
      aplicar(mk(8'h1D, 1'b1, 1'b1, "post_reset_1D"));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
